// File: rtl/pc_update_unit.sv
// Multicycle PC sequencer: drives an external combinational adder with pc and +1 or a
// sign-extended branch offset, captures the sum, then commits it to pc with a done pulse.
module pc_update_unit #(
  parameter int                DATA_W   = 8,
  parameter int                IMM_W    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [IMM_W-1:0]  imm,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic [DATA_W-1:0] add_in1,
  output logic [DATA_W-1:0] add_in2,
  input  logic [DATA_W-1:0] add_out,
  output logic [DATA_W-1:0] pc,
  output logic              done,
  output logic              taken
);

  // state  | meaning
  // S_IDLE | waiting for a request; op_ready high
  // S_CALC | adder driven with pc and +1/offset; sum captured on exit
  // S_WB   | captured sum committed to pc on exit, done pulsed
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB} state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_BZ  = 2'b10;

  state_t              state, state_nxt;
  logic [1:0]          op_r;
  logic [IMM_W-1:0]    imm_r;
  logic                flag_z_r, flag_n_r;
  logic [DATA_W-1:0]   pc_next;
  logic                taken_r;
  logic                take;
  logic [DATA_W-1:0]   imm_sext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (op_valid) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decision uses only latched operands so late flag/imm changes cannot leak in.
  always_comb begin
    case (op_r)
      OP_INC:  take = 1'b0;
      OP_BR:   take = 1'b1;
      OP_BZ:   take = flag_z_r;
      default: take = flag_n_r;
    endcase
  end

  assign imm_sext = {{(DATA_W-IMM_W){imm_r[IMM_W-1]}}, imm_r};

  always_comb begin
    op_ready = (state == S_IDLE);
    add_in1  = pc;
    add_in2  = '0;
    if (state == S_CALC) add_in2 = take ? imm_sext : DATA_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r     <= '0;
      imm_r    <= '0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
      pc_next  <= '0;
      taken_r  <= 1'b0;
      pc       <= RESET_PC;
      done     <= 1'b0;
      taken    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_r     <= op_code;
            imm_r    <= imm;
            flag_z_r <= flag_z;
            flag_n_r <= flag_n;
          end
        end
        S_CALC: begin
          pc_next <= add_out;
          taken_r <= take;
        end
        S_WB: begin
          pc    <= pc_next;
          done  <= 1'b1;
          taken <= taken_r;
        end
        default: ;
      endcase
    end
  end

endmodule
